// File: rtl/uart_pkg.sv
// Shared UART-subsystem types: transmit-arbiter FSM encoding and header defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HEADER,
        ARB_PAYLOAD,
        ARB_GAP
    } arb_state_t;

    localparam logic [7:0]  HEADER_BASE_DEFAULT = 8'hA0;
    localparam int unsigned GAP_CNT_W           = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side AXI-stream bundle plus the uart_tx byte channel of the transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_PORTS-1:0]            s_tvalid;
    logic [NUM_PORTS-1:0]            s_tlast;
    logic [NUM_PORTS-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]           m_tdata;
    logic                            m_tvalid;
    logic                            m_tready;
    logic [NUM_PORTS-1:0]            grant;
    logic                            busy;

    // Arbiter side
    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, grant, busy
    );

    // Requesters plus uart_tx side
    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, grant, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above 'last', wrapping around.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    logic [IW-1:0] cand;

    // Scan from lowest priority (last) to highest (last+1); the final hit is the winner.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(last) + N - k) % N);
            if (req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte channel among requesters,
// with optional source-ID header byte and post-packet idle gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned           NUM_PORTS   = 4,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter bit                    HEADER_EN   = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE = DATA_WIDTH'(HEADER_BASE_DEFAULT),
    parameter int unsigned           IDLE_GAP    = 0
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t             state_q,   state_d;
    logic [NUM_PORTS-1:0]   grant_q,   grant_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [IDX_W-1:0]       rr_last_q, rr_last_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NUM_PORTS-1:0]   pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    logic [DATA_WIDTH-1:0]  s_data_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  sel_tdata;
    logic                   sel_tvalid;
    logic                   sel_tlast;

    rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req     (bus.s_tvalid),
        .last    (rr_last_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign s_data_arr[g] = bus.s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Owner's stream, routed straight through so payload bytes see no added latency
    assign sel_tdata  = s_data_arr[idx_q];
    assign sel_tvalid = bus.s_tvalid[idx_q];
    assign sel_tlast  = bus.s_tlast[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            rr_last_q <= IDX_W'(NUM_PORTS - 1);
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            rr_last_q <= rr_last_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        idx_d        = idx_q;
        rr_last_d    = rr_last_q;
        gap_cnt_d    = gap_cnt_q;
        bus.m_tdata  = '0;
        bus.m_tvalid = 1'b0;
        bus.s_tready = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    idx_d   = pick_idx;
                    state_d = HEADER_EN ? ARB_HEADER : ARB_PAYLOAD;
                end
            end
            ARB_HEADER: begin
                bus.m_tdata  = HEADER_BASE + DATA_WIDTH'(idx_q);
                bus.m_tvalid = 1'b1;
                if (bus.m_tready) begin
                    state_d = ARB_PAYLOAD;
                end
            end
            ARB_PAYLOAD: begin
                bus.m_tdata  = sel_tdata;
                bus.m_tvalid = sel_tvalid;
                bus.s_tready = grant_q & {NUM_PORTS{bus.m_tready}};
                // Release ownership on the tlast beat; the finisher becomes lowest priority
                if (sel_tvalid && bus.m_tready && sel_tlast) begin
                    rr_last_d = idx_q;
                    grant_d   = '0;
                    if (IDLE_GAP > 0) begin
                        state_d   = ARB_GAP;
                        gap_cnt_d = GAP_CNT_W'(IDLE_GAP - 1);
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet ordering, round-robin, stalls, idle gap and reset.
module tb_uart_tx_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bif ();
    uart_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) gif ();

    uart_tx_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0), .IDLE_GAP(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    uart_tx_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0), .IDLE_GAP(4)
    ) dut_gap (
        .clk (clk),
        .rst (rst),
        .bus (gif.master)
    );

    // Requester model state for bif
    logic [7:0]     q_data [NP][$];
    bit             q_last [NP][$];
    int             sent     [NP];
    int             hold_at  [NP];
    int             hold_len [NP];
    logic [NP-1:0]  s_fire = '0;
    logic           m_fire = 1'b0;
    int             ready_stall = 0;
    int             rdy_cnt = 0;
    bit             stall_now;

    logic [7:0]     obs_data  [$];
    logic [NP-1:0]  obs_grant [$];
    logic [7:0]     prev_data = '0;
    bit             prev_stall = 1'b0;

    function automatic void push(input int p, input logic [7:0] d, input bit l);
        q_data[p].push_back(d);
        q_last[p].push_back(l);
    endfunction

    // Requesters and uart_tx ready model, driven just after each rising edge
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < NP; p++) begin
            if (s_fire[p] && q_data[p].size() > 0) begin
                void'(q_data[p].pop_front());
                void'(q_last[p].pop_front());
                sent[p]++;
            end
            stall_now = (sent[p] == hold_at[p]) && (hold_len[p] > 0) && (q_data[p].size() > 0);
            if (q_data[p].size() > 0 && !stall_now) begin
                bif.s_tvalid[p]          = 1'b1;
                bif.s_tdata[p*DW +: DW]  = q_data[p][0];
                bif.s_tlast[p]           = q_last[p][0];
            end else begin
                bif.s_tvalid[p]          = 1'b0;
                bif.s_tdata[p*DW +: DW]  = '0;
                bif.s_tlast[p]           = 1'b0;
            end
            if (stall_now) hold_len[p]--;
        end
        if (m_fire) rdy_cnt = ready_stall;
        if (rdy_cnt > 0) begin
            bif.m_tready = 1'b0;
            rdy_cnt--;
        end else begin
            bif.m_tready = 1'b1;
        end
    end

    // Beat capture and per-cycle invariants, sampled on the falling edge
    always @(negedge clk) begin
        s_fire = bif.s_tvalid & bif.s_tready;
        m_fire = bif.m_tvalid & bif.m_tready;
        if (!rst) begin
            if (m_fire) begin
                obs_data.push_back(bif.m_tdata);
                obs_grant.push_back(bif.grant);
            end
            checks++;
            if (!$onehot0(bif.grant) || ((bif.s_tready & ~bif.grant) != '0) ||
                !$onehot0(gif.grant) || ((gif.s_tready & ~gif.grant) != '0)) begin
                errors++;
                $display("FAIL grant_excl t=%0t grant=%b s_tready=%b gap_grant=%b gap_s_tready=%b",
                         $time, bif.grant, bif.s_tready, gif.grant, gif.s_tready);
            end
            if (prev_stall) begin
                checks++;
                if (bif.m_tvalid !== 1'b1 || bif.m_tdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable t=%0t got valid=%b data=%h want valid=1 data=%h",
                             $time, bif.m_tvalid, bif.m_tdata, prev_data);
                end
            end
            prev_stall = bif.m_tvalid & ~bif.m_tready;
            prev_data  = bif.m_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        bit empty;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int p = 0; p < NP; p++) if (q_data[p].size() != 0) empty = 1'b0;
            if (empty && !bif.busy && !bif.m_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.grant !== '0 || bif.m_tvalid !== 1'b0 || bif.busy !== 1'b0 || bif.s_tready !== '0) begin
            errors++;
            $display("FAIL reset_main got grant=%b valid=%b busy=%b s_tready=%b want all 0",
                     bif.grant, bif.m_tvalid, bif.busy, bif.s_tready);
        end
        checks++;
        if (gif.grant !== '0 || gif.m_tvalid !== 1'b0 || gif.busy !== 1'b0 || gif.s_tready !== '0) begin
            errors++;
            $display("FAIL reset_gap got grant=%b valid=%b busy=%b s_tready=%b want all 0",
                     gif.grant, gif.m_tvalid, gif.busy, gif.s_tready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_d [4] = '{8'hA1, 8'h11, 8'h22, 8'h33};
        bit ok;
        bit seen;
        obs_data.delete();
        obs_grant.delete();
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bif.m_tvalid !== 1'b1 || bif.m_tdata !== 8'hA1 || bif.grant !== 4'b0010) begin
            errors++;
            $display("FAIL t1_first_header got valid=%b data=%h grant=%b want 1 a1 0010",
                     bif.m_tvalid, bif.m_tdata, bif.grant);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bif.m_tvalid && bif.m_tready && bif.m_tdata == 8'h33) seen = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!seen || bif.busy !== 1'b0 || bif.grant !== '0) begin
            errors++;
            $display("FAIL t1_release got seen=%b busy=%b grant=%b want 1 0 0000",
                     seen, bif.busy, bif.grant);
        end
        wait_done(50, ok);
        checks++;
        if (!ok || obs_data.size() != 4) begin
            errors++;
            $display("FAIL t1_count got done=%b beats=%0d want 1 4", ok, obs_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_d[i] || obs_grant[i] !== 4'b0010) begin
                errors++;
                $display("FAIL t1_byte%0d got data=%h grant=%b want %h 0010",
                         i, obs_data[i], obs_grant[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_round_robin_all();
        logic [7:0] exp_d [12] = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12,
                                   8'hA2, 8'h21, 8'h22, 8'hA3, 8'h31, 8'h32};
        logic [NP-1:0] exp_g;
        bit ok;
        do_reset();
        obs_data.delete();
        obs_grant.delete();
        for (int p = 0; p < NP; p++) begin
            push(p, 8'((p << 4) + 1), 1'b0);
            push(p, 8'((p << 4) + 2), 1'b1);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || obs_data.size() != 12) begin
            errors++;
            $display("FAIL t2_count got done=%b beats=%0d want 1 12", ok, obs_data.size());
        end
        for (int i = 0; i < 12; i++) begin
            exp_g = NP'(1) << (i / 3);
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_d[i] || obs_grant[i] !== exp_g) begin
                errors++;
                $display("FAIL t2_byte%0d got data=%h grant=%b want %h %b",
                         i, obs_data[i], obs_grant[i], exp_d[i], exp_g);
            end
        end
    endtask

    task automatic test_rr_priority();
        logic [7:0]    exp_d [4] = '{8'hA3, 8'h77, 8'hA2, 8'h66};
        logic [NP-1:0] exp_g [4] = '{4'b1000, 4'b1000, 4'b0100, 4'b0100};
        bit ok;
        obs_data.delete();
        obs_grant.delete();
        push(2, 8'h55, 1'b1);
        wait_done(50, ok);
        checks++;
        if (!ok || obs_data.size() != 2 || obs_data[0] !== 8'hA2 || obs_data[1] !== 8'h55) begin
            errors++;
            $display("FAIL t3_solo got done=%b beats=%0d first=%h second=%h want 1 2 a2 55",
                     ok, obs_data.size(), obs_data[0], obs_data[1]);
        end
        obs_data.delete();
        obs_grant.delete();
        push(2, 8'h66, 1'b1);
        push(3, 8'h77, 1'b1);
        wait_done(50, ok);
        checks++;
        if (!ok || obs_data.size() != 4) begin
            errors++;
            $display("FAIL t3_count got done=%b beats=%0d want 1 4", ok, obs_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_d[i] || obs_grant[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL t3_byte%0d got data=%h grant=%b want %h %b",
                         i, obs_data[i], obs_grant[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_tvalid_stall();
        logic [7:0]    exp_d [6] = '{8'hA0, 8'h81, 8'h82, 8'h83, 8'hA1, 8'h91};
        logic [NP-1:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        bit ok;
        bit reached;
        int bad;
        obs_data.delete();
        obs_grant.delete();
        hold_at[0]  = sent[0] + 1;
        hold_len[0] = 50;
        push(0, 8'h81, 1'b0);
        push(0, 8'h82, 1'b0);
        push(0, 8'h83, 1'b1);
        push(1, 8'h91, 1'b1);
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            if (obs_data.size() >= 2) reached = 1'b1;
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bif.m_tvalid !== 1'b0 || bif.grant !== 4'b0001 || bif.s_tready[3:1] !== 3'b000 ||
                bif.busy !== 1'b1) bad++;
        end
        checks++;
        if (!reached || bad != 0) begin
            errors++;
            $display("FAIL t4_stall got reached=%b bad_cycles=%0d want 1 0", reached, bad);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || obs_data.size() != 6) begin
            errors++;
            $display("FAIL t4_count got done=%b beats=%0d want 1 6", ok, obs_data.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_d[i] || obs_grant[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL t4_byte%0d got data=%h grant=%b want %h %b",
                         i, obs_data[i], obs_grant[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_ready_stall();
        logic [7:0] exp_d [4] = '{8'hA2, 8'hC1, 8'hC2, 8'hC3};
        bit ok;
        obs_data.delete();
        obs_grant.delete();
        ready_stall = 8000;
        rdy_cnt     = 8000;
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b0);
        push(2, 8'hC3, 1'b1);
        repeat (100) @(negedge clk);
        checks++;
        if (bif.m_tvalid !== 1'b1 || bif.m_tready !== 1'b0 || bif.m_tdata !== 8'hA2 ||
            bif.grant !== 4'b0100 || bif.s_tready !== '0) begin
            errors++;
            $display("FAIL t5_held got valid=%b ready=%b data=%h grant=%b s_tready=%b want 1 0 a2 0100 0000",
                     bif.m_tvalid, bif.m_tready, bif.m_tdata, bif.grant, bif.s_tready);
        end
        wait_done(40000, ok);
        ready_stall = 0;
        checks++;
        if (!ok || obs_data.size() != 4) begin
            errors++;
            $display("FAIL t5_count got done=%b beats=%0d want 1 4", ok, obs_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_d[i] || obs_grant[i] !== 4'b0100) begin
                errors++;
                $display("FAIL t5_byte%0d got data=%h grant=%b want %h 0100",
                         i, obs_data[i], obs_grant[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_gap_and_reset();
        // Expected m_tvalid / busy on the 16 falling edges after port 0 starts requesting
        bit         exp_v [16] = '{1,1,0,0,0,0,0,1,1,0,0,0,0,0,1,1};
        bit         exp_b [16] = '{1,1,1,1,1,1,0,1,1,1,1,1,1,0,1,1};
        logic [7:0] exp_d [16] = '{8'hA0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA0,
                                   8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'h77};
        int gap_cycles;
        gif.s_tdata  = 32'h0000_005A;
        gif.s_tvalid = 4'b0001;
        gif.s_tlast  = 4'b0001;
        gap_cycles   = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (gif.busy && !gif.m_tvalid) gap_cycles++;
            checks++;
            if (gif.m_tvalid !== exp_v[n] || gif.busy !== exp_b[n] ||
                (exp_v[n] && gif.m_tdata !== exp_d[n])) begin
                errors++;
                $display("FAIL t6_cycle%0d got valid=%b busy=%b data=%h want %b %b %h",
                         n + 1, gif.m_tvalid, gif.busy, gif.m_tdata, exp_v[n], exp_b[n], exp_d[n]);
            end
            if (n == 9) begin
                gif.s_tdata  = 32'h0000_7700;
                gif.s_tvalid = 4'b0010;
                gif.s_tlast  = 4'b0000;
            end
        end
        checks++;
        if (gap_cycles != 8 || gif.grant !== 4'b0010) begin
            errors++;
            $display("FAIL t6_gap_count got gap_cycles=%0d grant=%b want 8 0010", gap_cycles, gif.grant);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (gif.grant !== '0 || gif.m_tvalid !== 1'b0 || gif.busy !== 1'b0 || gif.s_tready !== '0) begin
            errors++;
            $display("FAIL t6_mid_reset got grant=%b valid=%b busy=%b s_tready=%b want all 0",
                     gif.grant, gif.m_tvalid, gif.busy, gif.s_tready);
        end
        rst          = 1'b0;
        gif.s_tdata  = 32'h0000_775A;
        gif.s_tvalid = 4'b0011;
        gif.s_tlast  = 4'b0011;
        @(negedge clk);
        checks++;
        if (gif.grant !== 4'b0001 || gif.m_tvalid !== 1'b1 || gif.m_tdata !== 8'hA0) begin
            errors++;
            $display("FAIL t6_after_reset got grant=%b valid=%b data=%h want 0001 1 a0",
                     gif.grant, gif.m_tvalid, gif.m_tdata);
        end
        gif.s_tvalid = '0;
        gif.s_tlast  = '0;
    endtask

    initial begin
        bif.s_tdata  = '0;
        bif.s_tvalid = '0;
        bif.s_tlast  = '0;
        bif.m_tready = 1'b1;
        gif.s_tdata  = '0;
        gif.s_tvalid = '0;
        gif.s_tlast  = '0;
        gif.m_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            sent[p]     = 0;
            hold_at[p]  = -1;
            hold_len[p] = 0;
        end
        test_reset();
        test_single_packet();
        test_round_robin_all();
        test_rr_priority();
        test_tvalid_stall();
        test_ready_stall();
        test_gap_and_reset();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
